// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode-class helper for the multi-cycle ALU.
package alu_pkg;

   // Legacy 3-bit op set occupies 0..7; extended ops follow.
   localparam logic [3:0] OP_HLT = 4'd0;
   localparam logic [3:0] OP_SKZ = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_LDA = 4'd5;
   localparam logic [3:0] OP_STO = 4'd6;
   localparam logic [3:0] OP_JMP = 4'd7;
   localparam logic [3:0] OP_SUB = 4'd8;
   localparam logic [3:0] OP_OR  = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   // MUL is only legal when the iterative multiplier is built in.
   function automatic logic is_legal(input logic [3:0] op, input logic mul_en);
      return (op < OP_MUL) || ((op == OP_MUL) && mul_en);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               alu_clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic               busy_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_nxt;

   // Partial-product accumulate for the current multiplier bit.
   always_comb begin
      acc_nxt = acc_q;
      if (mplier_q[0]) begin
         acc_nxt = acc_q + mcand_q;
      end
   end

   // Final product is presented combinationally in the last iteration cycle.
   assign product = acc_nxt;
   assign done    = busy_q && (cnt_q == LAST);

   // Iteration state: load on start, then shift one bit per cycle.
   always_ff @(posedge alu_clk) begin
      if (reset) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, op_a};
         mplier_q <= op_b;
         acc_q    <= '0;
      end else if (busy_q) begin
         acc_q    <= acc_nxt;
         mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
         cnt_q    <= cnt_q + CW'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU with valid/ready issue and registered flags.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             alu_clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] accum,
   output logic [WIDTH-1:0] alu_out,
   output logic             out_valid,
   output logic             zero,
   output logic             carry,
   output logic             illegal,
   output logic             acc_zero
);

   logic [0:0]         state_q;
   logic [WIDTH-1:0]   alu_out_q;
   logic               zero_q;
   logic               carry_q;
   logic               illegal_q;
   logic               out_valid_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic               legal;
   logic               accept;
   logic               mul_start;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_done;

   assign in_ready  = (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign legal     = is_legal(opcode, MUL_EN);
   assign mul_start = accept && legal && (opcode == OP_MUL);
   assign sum       = {1'b0, accum} + {1'b0, data};
   assign acc_zero  = ~(|accum);

   // Single-cycle result; reserved opcodes and MUL fall through to zero.
   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      case (opcode)
         OP_HLT, OP_SKZ, OP_STO, OP_JMP: res_d = accum;
         OP_ADD: begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
         end
         OP_AND: res_d = accum & data;
         OP_XOR: res_d = accum ^ data;
         OP_LDA: res_d = data;
         OP_SUB: begin
            res_d   = accum - data;
            carry_d = (data > accum);
         end
         OP_OR:  res_d = accum | data;
         OP_SHL: begin
            res_d   = {accum[WIDTH-2:0], 1'b0};
            carry_d = accum[WIDTH-1];
         end
         OP_SHR: begin
            res_d   = {1'b0, accum[WIDTH-1:1]};
            carry_d = accum[0];
         end
         default: begin
            res_d   = '0;
            carry_d = 1'b0;
         end
      endcase
   end

   // Multiplier exists only when enabled; otherwise MUL never starts.
   if (MUL_EN) begin : g_mul
      alu_mul_iter #(
         .WIDTH(WIDTH)
      ) u_mul (
         .alu_clk (alu_clk),
         .reset   (reset),
         .start   (mul_start),
         .op_a    (accum),
         .op_b    (data),
         .product (mul_prod),
         .done    (mul_done)
      );
   end else begin : g_no_mul
      assign mul_prod = '0;
      assign mul_done = 1'b0;
   end

   // FSM and result/flag registers; all outputs move only on a result write.
   always_ff @(posedge alu_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         alu_out_q   <= '0;
         zero_q      <= 1'b1;
         carry_q     <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (mul_start) begin
               state_q <= ST_MUL;
            end else if (accept) begin
               alu_out_q   <= res_d;
               zero_q      <= (res_d == '0);
               carry_q     <= carry_d;
               illegal_q   <= ~legal;
               out_valid_q <= 1'b1;
            end
         end else if (mul_done) begin
            alu_out_q   <= mul_prod[WIDTH-1:0];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            carry_q     <= |mul_prod[2*WIDTH-1:WIDTH];
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
         end
      end
   end

   assign alu_out   = alu_out_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign illegal   = illegal_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against a behavioural model.
module tb_alu_mc;

   localparam int unsigned    W    = 8;
   localparam longint unsigned MASK = (64'd1 << W) - 1;

   logic         alu_clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [3:0]   opcode = 4'd0;
   logic [W-1:0] data = '0;
   logic [W-1:0] accum = '0;

   logic         in_ready, out_valid, zero, carry, illegal, acc_zero;
   logic [W-1:0] alu_out;
   logic         nm_in_ready, nm_out_valid, nm_zero, nm_carry, nm_illegal, nm_acc_zero;
   logic [W-1:0] nm_alu_out;

   alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
      .alu_clk(alu_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .data(data), .accum(accum), .alu_out(alu_out),
      .out_valid(out_valid), .zero(zero), .carry(carry), .illegal(illegal),
      .acc_zero(acc_zero)
   );

   alu_mc #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
      .alu_clk(alu_clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready),
      .opcode(opcode), .data(data), .accum(accum), .alu_out(nm_alu_out),
      .out_valid(nm_out_valid), .zero(nm_zero), .carry(nm_carry), .illegal(nm_illegal),
      .acc_zero(nm_acc_zero)
   );

   always #5 alu_clk = ~alu_clk;

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference behaviour of a single-cycle op, straight from the opcode table.
   task automatic ref_op(input logic [3:0] op, input longint unsigned a,
                         input longint unsigned d, output longint unsigned res,
                         output bit cy, output bit ill);
      res = 0; cy = 1'b0; ill = 1'b0;
      case (op)
         4'd0, 4'd1, 4'd6, 4'd7: res = a;
         4'd2: begin res = (a + d) & MASK; cy = (a + d) > MASK; end
         4'd3: res = a & d;
         4'd4: res = a ^ d;
         4'd5: res = d;
         4'd8: begin res = (a - d) & MASK; cy = (d > a); end
         4'd9: res = a | d;
         4'd10: begin res = (a * 2) & MASK; cy = (a >= (64'd1 << (W - 1))); end
         4'd11: begin res = a / 2; cy = (a % 2) == 1; end
         default: ill = 1'b1;
      endcase
   endtask

   // Model: cycles left on an in-flight MUL plus the architectural outputs.
   int              m_busy = 0;
   longint unsigned m_pend = 0;
   longint unsigned m_out = 0;
   bit              m_zero = 1'b1, m_carry = 1'b0, m_ill = 1'b0, m_valid = 1'b0;

   always @(posedge alu_clk) begin
      longint unsigned r;
      bit c, il;
      if (reset) begin
         m_busy = 0; m_out = 0; m_zero = 1'b1; m_carry = 1'b0; m_ill = 1'b0;
         m_valid = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_out = m_pend & MASK; m_zero = (m_out == 0);
               m_carry = (m_pend >> W) != 0; m_ill = 1'b0; m_valid = 1'b1;
            end
         end else if (in_valid) begin
            if (opcode == 4'd12) begin
               m_busy = W;
               m_pend = longint'(accum) * longint'(data);
            end else begin
               ref_op(opcode, longint'(accum), longint'(data), r, c, il);
               m_out = r; m_zero = (r == 0); m_carry = c; m_ill = il; m_valid = 1'b1;
            end
         end
      end
   end

   // Compare every cycle, away from the rising edge.
   always @(negedge alu_clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, (m_busy == 0));
         chk("out_valid", out_valid, m_valid);
         chk("alu_out", alu_out, m_out);
         chk("zero", zero, m_zero);
         chk("carry", carry, m_carry);
         chk("illegal", illegal, m_ill);
         chk("acc_zero", acc_zero, (accum == 0));
      end
   end

   // Present one op, drop in_valid after the edge, return mid-cycle after it.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
      opcode = op; accum = a; data = d; in_valid = 1'b1;
      @(posedge alu_clk); #1;
      in_valid = 1'b0;
      @(negedge alu_clk); #1;
   endtask

   initial begin
      @(posedge alu_clk); #1;
      chk_en = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge alu_clk);
      #1 reset = 1'b0;
      @(negedge alu_clk); #1;
      chk("rst alu_out", alu_out, 0);
      chk("rst zero", zero, 1);
      chk("rst carry", carry, 0);
      chk("rst illegal", illegal, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);

      // Back-to-back ADD then SUB.
      opcode = 4'd2; accum = 8'hFF; data = 8'h01; in_valid = 1'b1;
      @(posedge alu_clk); #1;
      opcode = 4'd8; accum = 8'h05; data = 8'h07;
      @(negedge alu_clk); #1;
      chk("add out_valid", out_valid, 1);
      chk("add alu_out", alu_out, 8'h00);
      chk("add zero", zero, 1);
      chk("add carry", carry, 1);
      @(posedge alu_clk); #1;
      in_valid = 1'b0;
      @(negedge alu_clk); #1;
      chk("sub out_valid", out_valid, 1);
      chk("sub alu_out", alu_out, 8'hFE);
      chk("sub carry", carry, 1);

      // MUL 0x10*0x11 with ignored in_valid while busy.
      opcode = 4'd12; accum = 8'h10; data = 8'h11; in_valid = 1'b1;
      @(posedge alu_clk); #1;
      opcode = 4'd5; data = 8'h3C;
      for (int k = 1; k <= 9; k++) begin
         @(negedge alu_clk); #1;
         chk("mul in_ready", in_ready, (k == 9));
         chk("mul out_valid", out_valid, (k == 9));
         if (k < 9) begin
            @(posedge alu_clk); #1;
            if (k == 8) in_valid = 1'b0;
         end
      end
      chk("mul alu_out", alu_out, 8'h10);
      chk("mul carry", carry, 1);

      issue(4'd10, 8'h81, 8'h00);
      chk("shl alu_out", alu_out, 8'h02);
      chk("shl carry", carry, 1);
      issue(4'd11, 8'h81, 8'h00);
      chk("shr alu_out", alu_out, 8'h40);
      chk("shr carry", carry, 1);

      issue(4'd14, 8'h55, 8'hAA);
      chk("rsv alu_out", alu_out, 0);
      chk("rsv illegal", illegal, 1);
      chk("rsv zero", zero, 1);
      issue(4'd5, 8'h00, 8'h3C);
      chk("lda alu_out", alu_out, 8'h3C);
      chk("lda illegal", illegal, 0);
      chk("lda zero", zero, 0);

      // Opcode 12 without a multiplier is reserved.
      issue(4'd12, 8'h03, 8'h04);
      chk("nomul illegal", nm_illegal, 1);
      chk("nomul alu_out", nm_alu_out, 0);
      chk("nomul zero", nm_zero, 1);
      chk("nomul out_valid", nm_out_valid, 1);
      chk("mul busy in_ready", in_ready, 0);
      repeat (10) @(negedge alu_clk);
      #1;
      chk("mul 3x4 alu_out", alu_out, 8'h0C);

      // Reset in cycle 4 of a MUL aborts it.
      opcode = 4'd12; accum = 8'h0F; data = 8'h0F; in_valid = 1'b1;
      @(posedge alu_clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge alu_clk);
      #1 reset = 1'b1;
      @(posedge alu_clk); #1;
      reset = 1'b0;
      @(negedge alu_clk); #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort alu_out", alu_out, 0);
      chk("abort zero", zero, 1);
      chk("abort carry", carry, 0);
      chk("abort illegal", illegal, 0);
      chk("abort in_ready", in_ready, 1);
      repeat (12) @(negedge alu_clk);
      #1;

      // Random traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         int unsigned sel;
         sel = $urandom_range(0, 7);
         accum    = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : W'($urandom);
         data     = ($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom);
         opcode   = 4'($urandom_range(0, 15));
         in_valid = ($urandom_range(0, 9) < 7);
         reset    = ($urandom_range(0, 299) == 0);
         @(negedge alu_clk); #1;
      end
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (12) @(negedge alu_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
